// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer controller: state encodings
// and the state type used by the FSM and exported on the state port.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } state_t;

endpackage

// File: rtl/down_counter_ld.sv
// Loadable down-counter datapath; load wins over en, en decrements by one.
module down_counter_ld #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;

  // Count register: load has priority, otherwise optional decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (en) begin
      count_r <= count_r - WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Programmable timer controller: sequences down_counter_ld with start,
// stop, pause, retrigger and one-shot/auto-reload terminal-count handling.
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  state_t           state_r;
  state_t           state_nx_s;
  logic [WIDTH-1:0] period_r;
  logic [WIDTH-1:0] period_nx_s;
  logic             reload_r;
  logic             reload_nx_s;
  logic             done_r;
  logic             done_nx_s;
  logic             busy_r;
  logic             cnt_load_s;
  logic             cnt_en_s;
  logic [WIDTH-1:0] cnt_load_val_s;
  logic [WIDTH-1:0] count_s;

  down_counter_ld #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_s),
    .load_val (cnt_load_val_s),
    .en       (cnt_en_s),
    .count    (count_s)
  );

  // Next-state, counter control and done decode; priority stop > start > pause > decrement.
  always_comb begin
    state_nx_s     = state_r;
    period_nx_s    = period_r;
    reload_nx_s    = reload_r;
    done_nx_s      = 1'b0;
    cnt_load_s     = 1'b0;
    cnt_en_s       = 1'b0;
    cnt_load_val_s = '0;
    if (stop) begin
      // Abort is a load of zero so the counter never needs its own clear.
      state_nx_s     = ST_IDLE;
      cnt_load_s     = 1'b1;
      cnt_load_val_s = '0;
    end else if (start && (load_val != '0)) begin
      period_nx_s    = load_val;
      reload_nx_s    = auto_reload;
      cnt_load_s     = 1'b1;
      cnt_load_val_s = load_val;
      state_nx_s     = pause ? ST_PAUSED : ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (pause) begin
            state_nx_s = ST_PAUSED;
          end else if (count_s > WIDTH'(1)) begin
            cnt_en_s = 1'b1;
          end else if (count_s == WIDTH'(1)) begin
            done_nx_s  = 1'b1;
            cnt_load_s = 1'b1;
            if (reload_r) begin
              cnt_load_val_s = period_r;
            end else begin
              cnt_load_val_s = '0;
              state_nx_s     = ST_IDLE;
            end
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            state_nx_s = ST_RUN;
          end else begin
            state_nx_s = ST_PAUSED;
          end
        end
        ST_IDLE: begin
          state_nx_s = ST_IDLE;
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // Control registers; busy is registered from the next state so it tracks state exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      period_r <= '0;
      reload_r <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      period_r <= period_nx_s;
      reload_r <= reload_nx_s;
      done_r   <= done_nx_s;
      busy_r   <= (state_nx_s == ST_RUN) || (state_nx_s == ST_PAUSED);
    end
  end

  assign count = count_s;
  assign busy  = busy_r;
  assign done  = done_r;
  assign state = state_r;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural timer model driven by the same input sequence.
module tb_countdown_timer_ctrl;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         pause = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic [1:0]   state;

  int total = 0;
  int bad = 0;

  // Model: 0 idle, 1 running, 2 paused (the published state codes).
  int m_state, m_count, m_period, m_reload, m_done;

  countdown_timer_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .load_val(load_val), .auto_reload(auto_reload),
    .count(count), .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_count = 0; m_period = 0; m_reload = 0; m_done = 0;
  endtask

  // Timer behaviour for one clock edge, straight from the rules.
  task automatic model_edge(input bit st, input bit sp, input bit pa, input int lv, input bit ar);
    m_done = 0;
    if (sp) begin
      m_state = 0; m_count = 0;
    end else if (st && lv != 0) begin
      m_period = lv; m_reload = ar; m_count = lv; m_state = pa ? 2 : 1;
    end else if (m_state == 1) begin
      if (pa) m_state = 2;
      else if (m_count == 1) begin
        m_done = 1;
        if (m_reload != 0) m_count = m_period;
        else begin m_count = 0; m_state = 0; end
      end else m_count = m_count - 1;
    end else if (m_state == 2 && !pa) begin
      m_state = 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(m_count));
    chk({tag, "_state"}, 32'(state), 32'(m_state));
    chk({tag, "_busy"},  32'(busy),  32'(m_state != 0));
    chk({tag, "_done"},  32'(done),  32'(m_done));
  endtask

  task automatic cyc(input string tag, input bit st, input bit sp, input bit pa, input int lv, input bit ar);
    @(negedge clk);
    start = st; stop = sp; pause = pa; load_val = W'(lv); auto_reload = ar;
    @(posedge clk);
    model_edge(st, sp, pa, lv, ar);
    #1;
    check_all(tag);
  endtask

  initial begin
    int n;
    int edges;
    bit st, sp, pa, ar;
    int lv;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // One-shot P=5.
    cyc("t1_start", 1'b1, 1'b0, 1'b0, 5, 1'b0);
    chk("t1_load", 32'(count), 32'd5);
    for (int i = 0; i < 5; i++) begin
      cyc("t1_run", 1'b0, 1'b0, 1'b0, 0, 1'b0);
      chk("t1_seq", 32'(count), 32'(4 - i));
      chk("t1_done", 32'(done), 32'(i == 4));
    end
    chk("t1_idle", 32'(state), 32'd0);

    // Auto-reload P=3: three dones in ten cycles.
    cyc("t2_start", 1'b1, 1'b0, 1'b0, 3, 1'b1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cyc("t2_run", 1'b0, 1'b0, 1'b0, 0, 1'b0);
      if (done) n++;
      chk("t2_state", 32'(state), 32'd1);
    end
    chk("t2_dones", 32'(n), 32'd3);
    cyc("t2_stop", 1'b0, 1'b1, 1'b0, 0, 1'b0);

    // Pause at count 4 for four edges: done lands 5 edges late (11 vs 6).
    cyc("t3_start", 1'b1, 1'b0, 1'b0, 6, 1'b0);
    cyc("t3_run", 1'b0, 1'b0, 1'b0, 0, 1'b0);
    cyc("t3_run", 1'b0, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc("t3_pause", 1'b0, 1'b0, 1'b1, 0, 1'b0);
      chk("t3_hold", 32'(count), 32'd4);
    end
    cyc("t3_exit", 1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("t3_exit_hold", 32'(count), 32'd4);
    edges = 7;
    for (int i = 0; i < 20 && !done; i++) begin
      cyc("t3_run", 1'b0, 1'b0, 1'b0, 0, 1'b0);
      edges++;
    end
    chk("t3_latency", 32'(edges), 32'd11);

    // Stop at count 7, then stop+start together.
    cyc("t4_start", 1'b1, 1'b0, 1'b0, 9, 1'b0);
    cyc("t4_run", 1'b0, 1'b0, 1'b0, 0, 1'b0);
    cyc("t4_run", 1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("t4_at7", 32'(count), 32'd7);
    cyc("t4_stop", 1'b0, 1'b1, 1'b0, 0, 1'b0);
    chk("t4_stop_count", 32'(count), 32'd0);
    cyc("t4_start2", 1'b1, 1'b0, 1'b0, 5, 1'b0);
    cyc("t4_both", 1'b1, 1'b1, 1'b0, 12, 1'b0);
    chk("t4_both_state", 32'(state), 32'd0);

    // Retrigger at count 2, then zero-period start in IDLE.
    cyc("t5_start", 1'b1, 1'b0, 1'b0, 8, 1'b0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cyc("t5_run", 1'b0, 1'b0, 1'b0, 0, 1'b0);
      if (done) n++;
    end
    chk("t5_at2", 32'(count), 32'd2);
    cyc("t5_retrig", 1'b1, 1'b0, 1'b0, 4, 1'b0);
    chk("t5_reload", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      cyc("t5_run", 1'b0, 1'b0, 1'b0, 0, 1'b0);
      if (done) n++;
    end
    chk("t5_dones", 32'(n), 32'd1);
    cyc("t5_zero", 1'b1, 1'b0, 1'b0, 0, 1'b1);
    chk("t5_zero_state", 32'(state), 32'd0);

    // Asynchronous reset between edges.
    cyc("t6_start", 1'b1, 1'b0, 1'b0, 10, 1'b0);
    cyc("t6_run", 1'b0, 1'b0, 1'b0, 0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("t6_async");
    @(negedge clk);
    rst = 1'b0;

    // P=31 full range, then P=1 auto-reload.
    cyc("t6_p31", 1'b1, 1'b0, 1'b0, 31, 1'b0);
    for (int i = 0; i < 31; i++) cyc("t6_p31_run", 1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("t6_p31_end", 32'(count), 32'd0);
    cyc("t6_p1", 1'b1, 1'b0, 1'b0, 1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc("t6_p1_run", 1'b0, 1'b0, 1'b0, 0, 1'b0);
      chk("t6_p1_done", 32'(done), 32'd1);
      chk("t6_p1_count", 32'(count), 32'd1);
    end
    cyc("t6_stop", 1'b0, 1'b1, 1'b0, 0, 1'b0);

    // Random traffic; zero-period start only while idle.
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 7) == 0);
      sp = ($urandom_range(0, 19) == 0);
      pa = ($urandom_range(0, 3) == 0);
      ar = 1'($urandom_range(0, 1));
      lv = (m_state == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(1, 31));
      cyc("rnd", st, sp, pa, lv, ar);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
